par_data_src: RTL and testbench

Parametrised synchronous parallel-data source for the sequential-logic bench and datapath blocks. It answers each rising edge of `ask_for_data` with a burst of 1..N data words on consecutive `sclk` cycles. Each word is generated by a selectable rule: increment, decrement, LFSR or hold. It reports wrap-around, busy and dropped requests, replacing ad-hoc stimulus counters with a synthesizable block.

---
 rtl/par_data_src.sv | 158 +++++++++++++++
 tb/tb_par_data_src.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/par_data_src.sv
// Parallel data source: each rising edge of ask_for_data produces a burst of
// 1..N words generated by an increment, decrement, LFSR or hold rule.
module par_data_src #(
  parameter int              WIDTH   = 4,
  parameter int              STEP    = 1,
  parameter int              LIMIT   = 15,
  parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
  parameter logic [WIDTH-1:0] SEED   = 4'd1,
  parameter int              BURST_W = 4
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               ask_for_data,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  output logic [WIDTH-1:0]   data,
  output logic               data_valid,
  output logic               busy,
  output logic               wrap,
  output logic               overrun
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [WIDTH:0]     STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]     LIMIT_X = (WIDTH+1)'(LIMIT);
  localparam logic [BURST_W-1:0] ZERO_B = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

  // Returns {wrap, next_data}; arithmetic is one bit wider so overflow is visible.
  function automatic logic [WIDTH:0] next_word(input logic [WIDTH-1:0] cur,
                                               input logic [1:0]       m);
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic [WIDTH-1:0] lfsr_v;
    logic [WIDTH:0]   res;
    cur_x  = {1'b0, cur};
    sum_x  = cur_x + STEP_X;
    diff_x = cur_x - STEP_X;
    lfsr_v = {1'b0, cur[WIDTH-1:1]} ^ (cur[0] ? TAPS : {WIDTH{1'b0}});
    res    = {1'b0, cur};
    case (m)
      2'b00: begin
        if (sum_x > LIMIT_X) res = {1'b1, {WIDTH{1'b0}}};
        else                 res = {1'b0, sum_x[WIDTH-1:0]};
      end
      2'b01: begin
        if (cur_x < STEP_X) res = {1'b1, LIMIT_X[WIDTH-1:0]};
        else                res = {1'b0, diff_x[WIDTH-1:0]};
      end
      2'b10: begin
        if (cur == {WIDTH{1'b0}}) res = {1'b0, SEED};
        else                      res = {(lfsr_v == SEED), lfsr_v};
      end
      2'b11:   res = {1'b0, cur};
      default: res = {1'b0, cur};
    endcase
    return res;
  endfunction

  state_t             state_r, state_s;
  logic [1:0]         mode_r, mode_s;
  logic [BURST_W-1:0] remaining_r, remaining_s;
  logic [WIDTH-1:0]   data_r, data_s;
  logic               data_valid_r, data_valid_s;
  logic               busy_r, busy_s;
  logic               wrap_r, wrap_s;
  logic               overrun_r, overrun_s;
  logic               ask_q_r;
  logic               req_s;
  logic [1:0]         rule_s;
  logic [BURST_W-1:0] len_s;
  logic [WIDTH:0]     nxt_s;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    req_s        = ask_for_data & ~ask_q_r;
    state_s      = state_r;
    mode_s       = mode_r;
    remaining_s  = remaining_r;
    data_s       = data_r;
    data_valid_s = 1'b0;
    busy_s       = 1'b0;
    wrap_s       = 1'b0;
    overrun_s    = overrun_r;
    len_s        = (burst_len == ZERO_B) ? ONE_B : burst_len;
    if (state_r == IDLE) rule_s = mode;
    else                 rule_s = mode_r;
    nxt_s = next_word(data_r, rule_s);
    case (state_r)
      IDLE: begin
        if (req_s) begin
          mode_s       = mode;
          data_s       = nxt_s[WIDTH-1:0];
          wrap_s       = nxt_s[WIDTH];
          data_valid_s = 1'b1;
          remaining_s  = len_s - ONE_B;
          if (remaining_s == ZERO_B) state_s = IDLE;
          else                       state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        data_s       = nxt_s[WIDTH-1:0];
        wrap_s       = nxt_s[WIDTH];
        data_valid_s = 1'b1;
        busy_s       = 1'b1;
        remaining_s  = remaining_r - ONE_B;
        if (remaining_r == ONE_B) state_s = IDLE;
        else                      state_s = BURST;
        // A request arriving mid-burst is lost but remembered.
        if (req_s) overrun_s = 1'b1;
        else       overrun_s = overrun_r;
      end
      default: begin
        state_s     = IDLE;
        remaining_s = ZERO_B;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_r      <= IDLE;
      mode_r       <= 2'b00;
      remaining_r  <= ZERO_B;
      data_r       <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      wrap_r       <= 1'b0;
      overrun_r    <= 1'b0;
      ask_q_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_r       <= mode_s;
      remaining_r  <= remaining_s;
      data_r       <= data_s;
      data_valid_r <= data_valid_s;
      busy_r       <= busy_s;
      wrap_r       <= wrap_s;
      overrun_r    <= overrun_s;
      ask_q_r      <= ask_for_data;
    end
  end

  assign data       = data_r;
  assign data_valid = data_valid_r;
  assign busy       = busy_r;
  assign wrap       = wrap_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_par_data_src.sv
// Scoreboard bench for par_data_src: expected words are queued when a request
// is driven and checked by a monitor as the DUT emits them.
module tb_par_data_src;

  localparam int STEP  = 1;
  localparam int LIMIT = 15;
  localparam int TAPS  = 12;
  localparam int SEED  = 1;

  logic       sclk = 1'b0;
  logic       rst;
  logic       ask_for_data;
  logic [1:0] mode;
  logic [3:0] burst_len;
  logic [3:0] data;
  logic       data_valid;
  logic       busy;
  logic       wrap;
  logic       overrun;

  typedef struct {
    int data;
    bit wrap;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   words_seen = 0;
  int   model_data = 0;

  par_data_src #(
    .WIDTH(4), .STEP(1), .LIMIT(15), .TAPS(4'b1100), .SEED(4'd1), .BURST_W(4)
  ) dut (
    .sclk(sclk), .rst(rst), .ask_for_data(ask_for_data), .mode(mode),
    .burst_len(burst_len), .data(data), .data_valid(data_valid),
    .busy(busy), .wrap(wrap), .overrun(overrun)
  );

  always #5 sclk = ~sclk;

  // Monitor: every emitted word must match the head of the scoreboard.
  always @(negedge sclk) begin
    if (data_valid === 1'b1) begin
      words_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data=%0d wrap=%b busy=%b, required no word", data, wrap, busy);
      end else begin
        mon_e = exp_q.pop_front();
        if (data !== 4'(mon_e.data) || wrap !== mon_e.wrap || busy !== mon_e.busy) begin
          n_err++;
          $display("FAIL word: got data=%0d wrap=%b busy=%b, required data=%0d wrap=%b busy=%b",
                   data, wrap, busy, mon_e.data, mon_e.wrap, mon_e.busy);
        end
      end
    end else begin
      n_cmp++;
      if (wrap !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_flags: got wrap=%b busy=%b with data_valid=%b, required 0 0", wrap, busy, data_valid);
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic model_step(input logic [1:0] m, inout int d, output bit w);
    int n;
    w = 1'b0;
    case (m)
      2'd0: if (d + STEP > LIMIT) begin d = 0; w = 1'b1; end else d = d + STEP;
      2'd1: if (d < STEP) begin d = LIMIT; w = 1'b1; end else d = d - STEP;
      2'd2: begin
        if (d == 0) d = SEED;
        else begin
          n = d / 2;
          if (d % 2 == 1) n = n ^ TAPS;
          d = n;
          w = (n == SEED);
        end
      end
      default: d = d;
    endcase
  endtask

  task automatic push_burst(input logic [1:0] m, input int len);
    int L;
    bit w;
    L = (len == 0) ? 1 : len;
    for (int k = 0; k < L; k++) begin
      model_step(m, model_data, w);
      exp_q.push_back('{model_data, w, (k > 0)});
    end
  endtask

  task automatic run_burst(input logic [1:0] m, input int len);
    int L;
    int start;
    L = (len == 0) ? 1 : len;
    start = words_seen;
    mode = m;
    burst_len = 4'(len);
    ask_for_data = 1'b1;
    push_burst(m, len);
    tick();
    ask_for_data = 1'b0;
    repeat (L + 2) tick();
    n_cmp++;
    if (words_seen - start !== L) begin
      n_err++;
      $display("FAIL word_count: got %0d words, required %0d", words_seen - start, L);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_words: got %0d unconsumed, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_data(input string name, input int req);
    n_cmp++;
    if (data !== 4'(req) || data_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got data=%0d valid=%b, required data=%0d valid=0", name, data, data_valid, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ask_for_data = 1'b0;
    mode = 2'b00;
    burst_len = 4'd0;
    repeat (3) tick();
    n_cmp++;
    if ({data, data_valid, busy, wrap, overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got %b, required 00000000", {data, data_valid, busy, wrap, overrun});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    run_burst(2'b00, 1);
    check_data("single_hold", 1);
  endtask

  task automatic test_inc_wrap();
    run_burst(2'b00, 12);
    check_data("inc_to_13", 13);
    run_burst(2'b00, 4);
    check_data("inc_wrap_end", 1);
  endtask

  task automatic test_dec();
    run_burst(2'b01, 3);
    check_data("dec_end", 14);
    run_burst(2'b01, 14);
    check_data("dec_to_0", 0);
  endtask

  task automatic test_lfsr();
    run_burst(2'b10, 0);
    check_data("lfsr_seed", 1);
    run_burst(2'b10, 15);
    check_data("lfsr_cycle_end", 1);
  endtask

  task automatic test_hold();
    run_burst(2'b11, 2);
    check_data("hold_end", 1);
  endtask

  task automatic test_overrun();
    int start;
    start = words_seen;
    mode = 2'b00;
    burst_len = 4'd4;
    ask_for_data = 1'b1;
    push_burst(2'b00, 4);
    tick();
    ask_for_data = 1'b0;
    tick();
    ask_for_data = 1'b1;
    tick();
    ask_for_data = 1'b0;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    repeat (5) tick();
    n_cmp++;
    if (words_seen - start !== 4) begin
      n_err++;
      $display("FAIL overrun_word_count: got %0d, required 4", words_seen - start);
    end
    run_burst(2'b00, 2);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_burst();
    int start;
    mode = 2'b00;
    burst_len = 4'd4;
    ask_for_data = 1'b1;
    push_burst(2'b00, 4);
    tick();
    ask_for_data = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({data, data_valid, busy, wrap, overrun} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_burst: got %b, required 00000000", {data, data_valid, busy, wrap, overrun});
    end
    n_cmp++;
    if (exp_q.size() != 2) begin
      n_err++;
      $display("FAIL words_before_reset: got %0d left, required 2", exp_q.size());
    end
    exp_q.delete();
    model_data = 0;
    ask_for_data = 1'b1;
    burst_len = 4'd2;
    tick();
    rst = 1'b0;
    start = words_seen;
    push_burst(2'b00, 2);
    repeat (8) tick();
    n_cmp++;
    if (words_seen - start !== 2) begin
      n_err++;
      $display("FAIL held_ask_words: got %0d, required 2", words_seen - start);
    end
    n_cmp++;
    if (exp_q.size() != 0 || data !== 4'd2) begin
      n_err++;
      $display("FAIL held_ask_end: got data=%0d left=%0d, required data=2 left=0", data, exp_q.size());
    end
    ask_for_data = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_inc_wrap();
    test_dec();
    test_lfsr();
    test_hold();
    test_overrun();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
